// File: rtl/regfile_mp_if.sv
// Register file access bundle: decode-side read addresses, writeback-side write
// port, clear request, and the combinational read data / busy flag coming back.
interface regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                 clear_req;
    logic                 we;
    logic [WIDTH/8-1:0]   wbe;
    logic [ADDR_W-1:0]    waddr;
    logic [WIDTH-1:0]     wdata;
    logic [ADDR_W-1:0]    raddr1;
    logic [ADDR_W-1:0]    raddr2;
    logic [WIDTH-1:0]     rdata1;
    logic [WIDTH-1:0]     rdata2;
    logic                 busy;

    modport master (
        output clear_req, we, wbe, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  clear_req, we, wbe, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2R/1W register file with byte enables and a hardware clear sequencer.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int NB = WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                busy;
    logic                wr_go;

    // Busy also covers the reset-asserted window so reads stay zero before the FSM is known.
    assign busy  = !rst_n || (state == CLEAR);
    assign wr_go = rst_n && (state == RUN) && bus.we && !bus.clear_req &&
                   !((ZERO_REG != 0) && (bus.waddr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.clear_req) begin
                        clr_ptr <= '0;
                    end else if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state   <= RUN;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Array has no reset; it is only ever zeroed by the clear sequencer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_go) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wbe[b]) mem[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    logic [WIDTH-1:0] st1, st2, val1, val2;
    logic             z1, z2;

    assign st1 = mem[bus.raddr1];
    assign st2 = mem[bus.raddr2];
    assign z1  = (ZERO_REG != 0) && (bus.raddr1 == '0);
    assign z2  = (ZERO_REG != 0) && (bus.raddr2 == '0);

`ifdef REGFILE_MP_BYPASS_EN
    logic [WIDTH-1:0] wmask;
    logic             byp1, byp2;

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{bus.wbe[b]}};
    end

    assign byp1 = wr_go && (bus.raddr1 == bus.waddr);
    assign byp2 = wr_go && (bus.raddr2 == bus.waddr);
    assign val1 = byp1 ? ((st1 & ~wmask) | (bus.wdata & wmask)) : st1;
    assign val2 = byp2 ? ((st2 & ~wmask) | (bus.wdata & wmask)) : st2;
`else
    assign val1 = st1;
    assign val2 = st2;
`endif

    assign bus.rdata1 = (busy || z1) ? '0 : val1;
    assign bus.rdata2 = (busy || z2) ? '0 : val2;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: instance a has ZERO_REG=1, instance b ZERO_REG=0.
module tb_regfile_mp;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .ADDR_W(AW)) ifa ();
    regfile_mp_if #(.WIDTH(W), .ADDR_W(AW)) ifb ();

    regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] mdl_a [D];
    logic [W-1:0] mdl_b [D];
    logic [W-1:0] exp_v;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [3:0] be,
                                           input logic [W-1:0] wd);
        logic [W-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input logic cr, input logic w, input logic [3:0] be,
                         input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        ifa.clear_req = cr; ifa.we = w; ifa.wbe = be; ifa.waddr = wa; ifa.wdata = wd;
        ifa.raddr1 = r1; ifa.raddr2 = r2;
        ifb.clear_req = cr; ifb.we = w; ifb.wbe = be; ifb.waddr = wa; ifb.wdata = wd;
        ifb.raddr1 = r1; ifb.raddr2 = r2;
    endtask

    task automatic model_wr(input logic [AW-1:0] wa, input logic [3:0] be, input logic [W-1:0] wd);
        if (wa != 0) mdl_a[wa] = merge(mdl_a[wa], be, wd);
        mdl_b[wa] = merge(mdl_b[wa], be, wd);
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin mdl_a[i] = '0; mdl_b[i] = '0; end
    endtask

    // Samples DEPTH busy cycles then the cycle busy drops; entered right after the start edge.
    task automatic busy_window(input string nm);
        for (int i = 0; i < D; i++) begin
            #1;
            checks++;
            if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1 || ifa.rdata1 !== '0 || ifb.rdata2 !== '0) begin
                failures++;
                $display("FAIL %s_busy cyc=%0d busy_a=%b busy_b=%b rd1_a=%h rd2_b=%h want busy=1 rd=0",
                         nm, i, ifa.busy, ifb.busy, ifa.rdata1, ifb.rdata2);
            end
            if (i == D - 1) drive(0, 0, 4'h0, 0, 0, ifa.raddr1, ifa.raddr2);
            @(negedge clk);
        end
        #1;
        checks++;
        if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0 || ifa.rdata1 !== '0 || ifb.rdata1 !== '0) begin
            failures++;
            $display("FAIL %s_done busy_a=%b busy_b=%b rd1_a=%h rd1_b=%h want busy=0 rd=0",
                     nm, ifa.busy, ifb.busy, ifa.rdata1, ifb.rdata1);
        end
        model_clear();
    endtask

    task automatic test_reset();
        drive(0, 0, 4'h0, 0, 0, 7, 7);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1 || ifa.rdata1 !== '0) begin
            failures++;
            $display("FAIL reset_hold busy_a=%b busy_b=%b rd1=%h want busy=1 rd=0",
                     ifa.busy, ifb.busy, ifa.rdata1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy_window("reset");
    endtask

    task automatic test_write();
        @(negedge clk);
        drive(0, 1, 4'hF, 5, 32'hDEADBEEF, 0, 0);
        model_wr(5, 4'hF, 32'hDEADBEEF);
        sb_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 5, 5);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata1 !== exp_v || ifa.rdata2 !== exp_v || ifb.rdata1 !== exp_v) begin
            failures++;
            $display("FAIL basic_write rd1_a=%h rd2_a=%h rd1_b=%h want %h",
                     ifa.rdata1, ifa.rdata2, ifb.rdata1, exp_v);
        end
    endtask

    task automatic test_byte_en();
        @(negedge clk);
        drive(0, 1, 4'h5, 5, 32'h11223344, 1, 1);
        model_wr(5, 4'h5, 32'h11223344);
        sb_q.push_back(32'hDE22BE44);
        @(negedge clk);
        drive(0, 1, 4'h0, 5, 32'h0, 5, 5);   // we with no byte enables writes nothing
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 5, 5);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata1 !== exp_v || ifb.rdata2 !== exp_v) begin
            failures++;
            $display("FAIL byte_en rd1_a=%h rd2_b=%h want %h", ifa.rdata1, ifb.rdata2, exp_v);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(0, 1, 4'hF, 0, 32'hFFFFFFFF, 1, 1);
        model_wr(0, 4'hF, 32'hFFFFFFFF);
        sb_q.push_back(32'h0);
        sb_q.push_back(32'hFFFFFFFF);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata1 !== exp_v || ifa.rdata2 !== exp_v) begin
            failures++;
            $display("FAIL zero_reg_a rd1=%h rd2=%h want %h", ifa.rdata1, ifa.rdata2, exp_v);
        end
        exp_v = sb_q.pop_front();
        checks++;
        if (ifb.rdata1 !== exp_v) begin
            failures++;
            $display("FAIL zero_reg_b rd1=%h want %h", ifb.rdata1, exp_v);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        drive(0, 1, 4'hF, 9, 32'h00000009, 0, 0);
        model_wr(9, 4'hF, 32'h00000009);
        @(negedge clk);
        drive(0, 1, 4'hF, 9, 32'hA5A5A5A5, 0, 9);
        sb_q.push_back(BYP ? 32'hA5A5A5A5 : 32'h00000009);
        model_wr(9, 4'hF, 32'hA5A5A5A5);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata2 !== exp_v || ifb.rdata2 !== exp_v) begin
            failures++;
            $display("FAIL same_cycle_full rd2_a=%h rd2_b=%h want %h", ifa.rdata2, ifb.rdata2, exp_v);
        end
        @(negedge clk);
        drive(0, 1, 4'h3, 9, 32'h00000000, 0, 9);
        sb_q.push_back(BYP ? 32'hA5A50000 : 32'hA5A5A5A5);
        model_wr(9, 4'h3, 32'h00000000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata2 !== exp_v || ifb.rdata2 !== exp_v) begin
            failures++;
            $display("FAIL same_cycle_partial rd2_a=%h rd2_b=%h want %h", ifa.rdata2, ifb.rdata2, exp_v);
        end
        // Address 0 write with same-cycle read: a stays zero, b forwards only with bypass
        @(negedge clk);
        drive(0, 1, 4'hF, 0, 32'h0F0F0F0F, 0, 9);
        sb_q.push_back(BYP ? 32'h0F0F0F0F : mdl_b[0]);
        model_wr(0, 4'hF, 32'h0F0F0F0F);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (ifa.rdata1 !== '0 || ifb.rdata1 !== exp_v) begin
            failures++;
            $display("FAIL same_cycle_zero rd1_a=%h want 0 rd1_b=%h want %h", ifa.rdata1, ifb.rdata1, exp_v);
        end
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0, 9);
        #1;
        checks++;
        if (ifa.rdata2 !== 32'hA5A50000 || ifb.rdata2 !== 32'hA5A50000 || ifb.rdata1 !== 32'h0F0F0F0F) begin
            failures++;
            $display("FAIL same_cycle_next rd2_a=%h rd2_b=%h want a5a50000 rd1_b=%h want 0f0f0f0f",
                     ifa.rdata2, ifb.rdata2, ifb.rdata1);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] wa, prev;
        logic [3:0]    be;
        logic [W-1:0]  wd, ea, eb;
        prev = 5'd5;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            wa = AW'($urandom_range(31, 1));
            be = 4'($urandom_range(15, 0));
            wd = $urandom;
            drive(0, 1, be, wa, wd, prev, prev);
            ea = (BYP && prev == wa) ? merge(mdl_a[prev], be, wd) : mdl_a[prev];
            eb = (BYP && prev == wa) ? merge(mdl_b[prev], be, wd) : mdl_b[prev];
            sb_q.push_back(ea);
            sb_q.push_back(eb);
            model_wr(wa, be, wd);
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (ifa.rdata1 !== exp_v) begin
                failures++;
                $display("FAIL b2b_a i=%0d addr=%0d got=%h want %h", i, prev, ifa.rdata1, exp_v);
            end
            exp_v = sb_q.pop_front();
            checks++;
            if (ifb.rdata2 !== exp_v) begin
                failures++;
                $display("FAIL b2b_b i=%0d addr=%0d got=%h want %h", i, prev, ifb.rdata2, exp_v);
            end
            prev = wa;
        end
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            drive(0, 0, 4'h0, 0, 0, AW'(i), AW'(D - 1 - i));
            sb_q.push_back(i == 0 ? 32'h0 : mdl_a[i]);
            sb_q.push_back(mdl_a[D - 1 - i]);
            sb_q.push_back(mdl_b[i]);
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (ifa.rdata1 !== exp_v) begin
                failures++;
                $display("FAIL readback_a1 addr=%0d got=%h want %h", i, ifa.rdata1, exp_v);
            end
            exp_v = sb_q.pop_front();
            checks++;
            if (ifa.rdata2 !== exp_v) begin
                failures++;
                $display("FAIL readback_a2 addr=%0d got=%h want %h", D - 1 - i, ifa.rdata2, exp_v);
            end
            exp_v = sb_q.pop_front();
            checks++;
            if (ifb.rdata1 !== exp_v) begin
                failures++;
                $display("FAIL readback_b1 addr=%0d got=%h want %h", i, ifb.rdata1, exp_v);
            end
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        drive(0, 1, 4'hF, 3, 32'hCAFEF00D, 0, 0);
        model_wr(3, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        drive(1, 1, 4'hF, 3, 32'h12345678, 3, 3);
        #1;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.rdata1 !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL clear_pre busy=%b rd1=%h want busy=0 rd=cafef00d", ifa.busy, ifa.rdata1);
        end
        @(negedge clk);
        drive(0, 1, 4'hF, 3, 32'hFFFFFFFF, 3, 3);
        busy_window("clear");
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        drive(1, 0, 4'h0, 0, 0, 7, 7);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 7, 7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1) begin
            failures++;
            $display("FAIL midclear_rst busy_a=%b busy_b=%b want 1", ifa.busy, ifb.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy_window("midclear");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_write();
        test_byte_en();
        test_zero_reg();
        test_same_cycle();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
